// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and mod-26 helpers for the rotor datapath.
package enigma_pkg;

    localparam logic [5:0] ALPHA_N  = 6'd26;
    localparam logic [7:0] ASCII_A  = 8'd65;
    localparam int         WIRING_W = 208;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } rotor_state_e;

    // (a + b) mod 26 for operands already in 0..25.
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_N) s = s - ALPHA_N;
        return s[4:0];
    endfunction

    // (a - b) mod 26, biased by +26 so no intermediate goes negative.
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + ALPHA_N - {1'b0, b};
        if (s >= ALPHA_N) s = s - ALPHA_N;
        return s[4:0];
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= 8'd90);
    endfunction

    // ASCII letter to 0..25; anything else maps to 0.
    function automatic logic [4:0] to_idx(input logic [7:0] c);
        logic [7:0] t;
        t = c - ASCII_A;
        return is_letter(c) ? t[4:0] : 5'd0;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [4:0] i);
        return {3'b000, i} + ASCII_A;
    endfunction

    // Reduce an arbitrary byte into 0..25 (only matters for non-letter wiring).
    function automatic logic [4:0] mod26_byte(input logic [7:0] c);
        logic [7:0] r;
        r = c % 8'd26;
        return r[4:0];
    endfunction

endpackage

// File: rtl/rotor_map.sv
// Combinational rotor lookup: forward substitution or inverse search through
// the wiring table, both relative to the effective rotor position.
module rotor_map
    import enigma_pkg::*;
(
    input  logic [WIRING_W-1:0] wiring,
    input  logic [7:0]          din,
    input  logic [4:0]          pos,
    input  logic                rev,
    output logic [7:0]          dout
);

    logic [4:0] offset;
    logic [7:0] fwd_byte;
    logic       match;
    logic [4:0] match_idx;

    // Non-letters pass straight through; letters are shifted by the position,
    // substituted (or inverse-searched), then shifted back.
    always_comb begin
        dout      = din;
        offset    = 5'd0;
        fwd_byte  = 8'd0;
        match     = 1'b0;
        match_idx = 5'd0;
        if (is_letter(din)) begin
            offset = add26(to_idx(din), pos);
            if (!rev) begin
                for (int i = 0; i < 26; i++) begin
                    if (offset == 5'(i)) fwd_byte = wiring[WIRING_W-1-8*i -: 8];
                end
                dout = to_ascii(sub26(mod26_byte(fwd_byte - ASCII_A), pos));
            end else begin
                // Descending scan so the lowest matching index wins.
                for (int i = 25; i >= 0; i--) begin
                    if (wiring[WIRING_W-1-8*i -: 8] == to_ascii(offset)) begin
                        match     = 1'b1;
                        match_idx = 5'(i);
                    end
                end
                dout = match ? to_ascii(sub26(match_idx, pos)) : din;
            end
        end
    end

endmodule

// File: rtl/rotor_stage.sv
// One Enigma-style rotor stage: position counter with notch carry, wiring
// storage, and a three-state IDLE/CALC/DONE character pipeline.
// Optional ring setting: define ROTOR_RING_EN to add the ring_in port.
//
// Handshake: valid is sampled only in IDLE; the character is mapped with the
// values in force at the accepting edge, and done pulses for exactly one cycle
// (the DONE state) with dout valid; nothing is queued while busy.
module rotor_stage
    import enigma_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                set,
    input  logic [WIRING_W-1:0] idx_in,
    input  logic [7:0]          pos_in,
    input  logic [7:0]          notch_in,
    input  logic                step_in,
    input  logic                valid,
    input  logic [7:0]          din,
    input  logic                rev,
`ifdef ROTOR_RING_EN
    input  logic [7:0]          ring_in,
`endif
    output logic [7:0]          dout,
    output logic                done,
    output logic                step_out,
    output logic [7:0]          pos_out
);

    rotor_state_e          state_q, state_d;
    logic [WIRING_W-1:0]   wiring_q, wiring_d;
    logic [4:0]            p_q, p_d;
    logic [7:0]            notch_q, notch_d;
    logic [4:0]            ring_d;
    logic [7:0]            res_q, res_d;
    logic [7:0]            dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  step_out_q, step_out_d;
    logic [4:0]            eff_pos;
    logic [7:0]            map_dout;

`ifdef ROTOR_RING_EN
    logic [4:0]            ring_q;

    // Ring setting follows set; it only shifts the effective position.
    always_comb begin
        ring_d = ring_q;
        if (set) ring_d = to_idx(ring_in);
    end

    // Ring register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ring_q <= 5'd0;
        else          ring_q <= ring_d;
    end
`else
    assign ring_d = 5'd0;
`endif

    // Configuration load and position stepping; set overrides a same-cycle step.
    always_comb begin
        wiring_d   = wiring_q;
        p_d        = p_q;
        notch_d    = notch_q;
        step_out_d = 1'b0;
        if (set) begin
            wiring_d = idx_in;
            p_d      = to_idx(pos_in);
            notch_d  = notch_in;
        end else if (step_in) begin
            p_d        = add26(p_q, 5'd1);
            step_out_d = (to_ascii(p_q) == notch_q);
        end
    end

    // The character is mapped with next-cycle values, so a same-edge step
    // (or set) is already applied; the result is frozen until DONE.
    assign eff_pos = sub26(p_d, ring_d);

    rotor_map u_map (
        .wiring (wiring_d),
        .din    (din),
        .pos    (eff_pos),
        .rev    (rev),
        .dout   (map_dout)
    );

    // Next-state and output logic for the character pipeline.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        dout_d  = 8'd0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_CALC;
                    res_d   = map_dout;
                end
            end
            ST_CALC: begin
                state_d = ST_DONE;
                dout_d  = res_q;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wiring_q   <= '0;
            p_q        <= 5'd0;
            notch_q    <= 8'd0;
            res_q      <= 8'd0;
            dout_q     <= 8'd0;
            done_q     <= 1'b0;
            step_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wiring_q   <= wiring_d;
            p_q        <= p_d;
            notch_q    <= notch_d;
            res_q      <= res_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            step_out_q <= step_out_d;
        end
    end

    assign dout     = dout_q;
    assign done     = done_q;
    assign step_out = step_out_q;
    assign pos_out  = to_ascii(p_q);

endmodule

// File: tb/tb_rotor_stage.sv
// Bench for rotor_stage: directed cases plus randomized characters checked
// against an integer-arithmetic reference model.
module tb_rotor_stage;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         set;
  logic [207:0] idx_in;
  logic [7:0]   pos_in;
  logic [7:0]   notch_in;
  logic         step_in;
  logic         valid;
  logic [7:0]   din;
  logic         rev;
`ifdef ROTOR_RING_EN
  logic [7:0]   ring_in;
`endif
  logic [7:0]   dout;
  logic         done;
  logic         step_out;
  logic [7:0]   pos_out;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // reference model state
  int m_w[26];
  int m_p;
  int m_notch;
  int m_ring;
  logic [7:0] w_arr[26];

  always #5 clk = ~clk;

  rotor_stage dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set      (set),
    .idx_in   (idx_in),
    .pos_in   (pos_in),
    .notch_in (notch_in),
    .step_in  (step_in),
    .valid    (valid),
    .din      (din),
    .rev      (rev),
`ifdef ROTOR_RING_EN
    .ring_in  (ring_in),
`endif
    .dout     (dout),
    .done     (done),
    .step_out (step_out),
    .pos_out  (pos_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_map(input int d, input bit r);
    int eff;
    int off;
    eff = (m_p - m_ring + 26) % 26;
    if (d < 65 || d > 90) return d;
    off = (d - 65 + eff) % 26;
    if (!r) return ((m_w[off] - 65) - eff + 26) % 26 + 65;
    for (int i = 0; i < 26; i++)
      if (m_w[i] - 65 == off) return (i - eff + 26) % 26 + 65;
    return d;
  endfunction

  task automatic set_w_from_str(input string s);
    for (int i = 0; i < 26; i++) w_arr[i] = s[i];
  endtask

  task automatic shuffle_w();
    logic [7:0] t;
    int j;
    for (int i = 0; i < 26; i++) w_arr[i] = 8'(65 + i);
    for (int i = 25; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = w_arr[i]; w_arr[i] = w_arr[j]; w_arr[j] = t;
    end
  endtask

  // Drive a set pulse for the next edge (caller ticks), then update the model.
  task automatic drive_set(input logic [7:0] pos, input logic [7:0] notch, input logic [7:0] ring);
    for (int i = 0; i < 26; i++) idx_in[207-8*i -: 8] = w_arr[i];
    pos_in = pos;
    notch_in = notch;
    set = 1'b1;
`ifdef ROTOR_RING_EN
    ring_in = ring;
`endif
  endtask

  task automatic model_set(input logic [7:0] pos, input logic [7:0] notch, input logic [7:0] ring);
    for (int i = 0; i < 26; i++) m_w[i] = int'(w_arr[i]);
    m_p = int'(pos) - 65;
    m_notch = int'(notch);
`ifdef ROTOR_RING_EN
    m_ring = int'(ring) - 65;
`else
    m_ring = (ring == 8'd0) ? 0 : 0;
`endif
  endtask

  task automatic load(input logic [7:0] pos, input logic [7:0] notch, input logic [7:0] ring);
    drive_set(pos, notch, ring);
    tick();
    set = 1'b0;
    model_set(pos, notch, ring);
    check_eq("load_pos", pos_out, 32'(m_p + 65));
  endtask

  task automatic send_char(input logic [7:0] d, input bit r, input bit with_step, output logic [7:0] got);
    valid = 1'b1; din = d; rev = r; step_in = with_step;
    tick();
    valid = 1'b0; step_in = 1'b0;
    din = 8'($urandom); rev = 1'($urandom);
    if (with_step) m_p = (m_p + 1) % 26;
    exp_q.push_back(8'(model_map(int'(d), r)));
    check_eq("calc_done_low", done, 0);
    tick();
    got = dout;
    check_eq("done_pulse", done, 1);
    check_eq("dout", dout, exp_q.pop_front());
    tick();
    check_eq("done_clear", done, 0);
    check_eq("dout_clear", dout, 0);
  endtask

  task automatic step_pulse();
    int pre;
    pre = m_p;
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    m_p = (m_p + 1) % 26;
    check_eq("step_pos", pos_out, 32'(m_p + 65));
    check_eq("step_out", step_out, (pre + 65 == m_notch) ? 1 : 0);
    tick();
    check_eq("step_out_clear", step_out, 0);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] ex;
    int d;
    reset_n = 1'b0; set = 1'b0; idx_in = '0; pos_in = 8'd0; notch_in = 8'd0;
    step_in = 1'b0; valid = 1'b0; din = 8'd0; rev = 1'b0;
`ifdef ROTOR_RING_EN
    ring_in = 8'd0;
`endif
    m_p = 0; m_notch = 0; m_ring = 0;
    tick(); tick();
    check_eq("rst_dout", dout, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_step_out", step_out, 0);
    check_eq("rst_pos", pos_out, 8'h41);
    reset_n = 1'b1;
    tick();

    // Directed reference-wiring cases
    set_w_from_str("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    load("A", "Q", "A");
    send_char("A", 1'b0, 1'b0, got);
    check_eq("fwd_A_to_E", got, "E");
    send_char("E", 1'b1, 1'b0, got);
    check_eq("rev_E_to_A", got, "A");
    send_char("A", 1'b0, 1'b1, got);
    check_eq("step_valid_dout", got, "J");
    check_eq("step_valid_pos", pos_out, "B");

    load("Q", "Q", "A");
    step_pulse();
    check_eq("notch_pos_R", pos_out, "R");
    load("Z", "Q", "A");
    step_pulse();
    check_eq("wrap_pos_A", pos_out, "A");

    send_char(8'h20, 1'b0, 1'b0, got);
    check_eq("nonletter_pass", got, 8'h20);

    // set and step on the same edge: set wins, no carry
    load("Q", "Q", "A");
    drive_set("D", "Q", "A");
    step_in = 1'b1;
    tick();
    set = 1'b0; step_in = 1'b0;
    model_set("D", "Q", "A");
    check_eq("set_wins_pos", pos_out, "D");
    check_eq("set_wins_no_carry", step_out, 0);

`ifdef ROTOR_RING_EN
    load("A", "Q", "B");
    send_char("A", 1'b0, 1'b0, got);
    check_eq("ring_B_dout", got, "K");
    load("A", "Q", "A");
`endif

    // Step during CALC: in-flight char keeps the accepted position
    valid = 1'b1; din = "C"; rev = 1'b0;
    tick();
    valid = 1'b0;
    ex = 8'(model_map("C", 1'b0));
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    m_p = (m_p + 1) % 26;
    check_eq("inflight_step_dout", dout, ex);
    check_eq("inflight_step_pos", pos_out, 32'(m_p + 65));
    tick();

    // Set during CALC: in-flight char keeps old wiring and position
    valid = 1'b1; din = "M"; rev = 1'b1;
    tick();
    valid = 1'b0;
    ex = 8'(model_map("M", 1'b1));
    shuffle_w();
    drive_set("K", "B", "A");
    tick();
    set = 1'b0;
    model_set("K", "B", "A");
    check_eq("inflight_set_dout", dout, ex);
    check_eq("inflight_set_pos", pos_out, "K");
    tick();

    // valid held during CALC is ignored, nothing is queued
    valid = 1'b1; din = "B"; rev = 1'b0;
    tick();
    ex = 8'(model_map("B", 1'b0));
    din = "X";
    tick();
    valid = 1'b0;
    check_eq("busy_valid_dout", dout, ex);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("busy_valid_no_done", done, 0);
    end

    // Randomized traffic
    for (int it = 0; it < 48; it++) begin
      if (it % 8 == 0) begin
        shuffle_w();
        load(8'(65 + $urandom_range(0, 25)), 8'(65 + $urandom_range(0, 25)),
             8'(65 + $urandom_range(0, 25)));
      end
      if ($urandom_range(0, 3) == 0) step_pulse();
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 255);
      else d = 65 + $urandom_range(0, 25);
      send_char(8'(d), 1'($urandom), 1'($urandom_range(0, 1)), got);
    end

    // Reset during CALC aborts the character
    set_w_from_str("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    load("G", "Q", "A");
    valid = 1'b1; din = "A"; rev = 1'b0;
    tick();
    valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_dout", dout, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_step_out", step_out, 0);
    check_eq("abort_pos", pos_out, 8'h41);
    tick();
    reset_n = 1'b1;
    m_p = 0; m_notch = 0; m_ring = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("abort_no_done", done, 0);
    end
    check_eq("abort_pos_after", pos_out, 8'h41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotor_stage.md
ROTOR_STAGE -- requirements
Module: rotor_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 set  input  1  load wiring, position and notch this cycle.
REQ-004 idx_in  input  208  wiring table, 26 ASCII letters; letter for 'A' in [207:200], for 'Z' in [7:0].
REQ-005 pos_in  input  8  initial rotor position, ASCII 'A'..'Z'.
REQ-006 notch_in  input  8  notch letter, ASCII 'A'..'Z'.
REQ-007 step_in  input  1  advance rotor one position (single-cycle pulse).
REQ-008 valid  input  1  din holds a character to map.
REQ-009 din  input  8  ASCII character.
REQ-010 rev  input  1  0 = forward pass (toward reflector), 1 = return pass; sampled with valid.
REQ-011 dout  output  8  mapped ASCII character.
REQ-012 done  output  1  dout valid, one-cycle pulse.
REQ-013 step_out  output  1  carry pulse to next rotor.
REQ-014 pos_out  output  8  current position, ASCII.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE->CALC when valid; CALC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-016 valid sampled only in IDLE; valid in CALC/DONE is ignored, no queueing.
REQ-017 din, rev latched on the accepting edge; done=1 and dout valid exactly during DONE (latency 2 edges from accept).
REQ-018 dout, done registered; dout = 0x00 and done = 0 outside DONE.
REQ-019 Position p held as 0..25; offset = (din-65+p) mod 26.
REQ-020 Forward: dout = ((idx_in[offset]-65) - p + 26) mod 26 + 65.
REQ-021 Return: find i with idx_in[i]-65 == offset; dout = (i - p + 26) mod 26 + 65; no match -> dout = din.
REQ-022 din outside 'A'..'Z': dout = din unchanged, done still pulses on schedule.
REQ-023 step_in: p <= (p+1) mod 26; 'Z' wraps to 'A'.
REQ-024 step_out = 1 for one cycle after a step edge whose pre-step p equals notch.
REQ-025 step_in and valid on same edge: step applies first; the character maps with the stepped position.
REQ-026 step_in during CALC/DONE: position updates immediately; in-flight character keeps position latched at accept.
REQ-027 set and step_in same edge: set wins, no step, no step_out.
REQ-028 set loads wiring, p, notch in any state; in-flight character completes with previously latched values.
REQ-029 All mod-26 arithmetic in ≥6-bit unsigned, no negative intermediates.

Reset
REQ-030 reset_n low: state IDLE, wiring all zero, p = 0, notch = 0, dout = 0x00, done = 0, step_out = 0, pos_out = 'A'.
REQ-031 Reset mid-operation aborts the character; no done is produced after release.

Configuration
REQ-032 ROTOR_RING_EN defined: extra input ring_in[7:0] (ASCII) latched on set; effective position = (p - ring + 26) mod 26 in REQ-019..021.
REQ-033 ROTOR_RING_EN undefined: no ring_in port; ring treated as 'A' (zero offset).

Structure
REQ-034 Shared package enigma_pkg: ALPHA_N = 26, ASCII_A = 65, WIRING_W = 208, FSM state typedef, mod-26 add/sub functions.
REQ-035 One sub-module rotor_map: combinational forward/return lookup from wiring, offset and rev; FSM, position counter and registers stay in rotor_stage.

Verification
REQ-036 Wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ, pos 'A', valid din 'A' rev 0 -> dout 'E', done high exactly 2 edges after accept.
REQ-037 Same wiring, pos 'A', din 'E' rev 1 -> dout 'A'.
REQ-038 Pos 'A', step_in and valid din 'A' same edge -> pos_out 'B', dout 'J'.
REQ-039 Notch 'Q', pos 'Q', step_in -> pos_out 'R', step_out one cycle; pos 'Z' step_in -> pos_out 'A', no step_out.
REQ-040 valid re-asserted during CALC ignored; reset_n low during CALC -> done never pulses, all outputs at reset values.
REQ-041 din 0x20 -> dout 0x20, done pulses; with ROTOR_RING_EN, ring 'B', pos 'A', din 'A' -> dout 'K'.
